// File: rtl/camera_pkg.sv
// Shared camera-path constants and the frame streamer state encoding.
// Defaults describe a 320x240 RGB444 frame buffer.
package camera_pkg;

    localparam int DEF_NUM_PIXELS = 76800;
    localparam int DEF_ADDR_W     = 17;
    localparam int DEF_PIX_W      = 12;

    localparam logic [DEF_PIX_W-1:0] DEF_HEADER_PIXEL = 12'h00A;

    typedef enum logic [2:0] {
        IDLE,
        HEADER,
        FETCH,
        LOAD,
        PRESENT,
        DONE
    } state_t;

endpackage

// File: rtl/frame_pixel_streamer.sv
// Streams one frame from the frame buffer to the serializer: header pixel,
// then every image pixel, with a ready/valid handshake on the output side.
module frame_pixel_streamer
    import camera_pkg::*;
#(
    parameter int                NUM_PIXELS   = DEF_NUM_PIXELS,
    parameter int                ADDR_W       = DEF_ADDR_W,
    parameter int                PIX_W        = DEF_PIX_W,
    parameter logic [PIX_W-1:0]  HEADER_PIXEL = PIX_W'(DEF_HEADER_PIXEL)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] rd_address,
    input  logic [PIX_W-1:0]  rd_data,
    output logic              frame_hold,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pix_cnt;
    logic              last_pix;

    assign last_pix = (pix_cnt == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        out_valid = 1'b0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        case (state)
            IDLE:    if (start) state_nxt = HEADER;
            HEADER: begin
                out_valid = 1'b1;
                out_sop   = 1'b1;
                if (out_ready) state_nxt = FETCH;
            end
            FETCH:   state_nxt = LOAD;
            LOAD:    state_nxt = PRESENT;
            PRESENT: begin
                out_valid = 1'b1;
                out_eop   = last_pix;
                if (out_ready) state_nxt = last_pix ? DONE : FETCH;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_hold = busy;
    assign done       = (state == DONE);

    // The address is loaded on the way into FETCH so the synchronous RAM
    // samples it at the end of FETCH and its data is ready to capture in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt    <= '0;
            rd_address <= '0;
            out_data   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    pix_cnt  <= '0;
                    out_data <= HEADER_PIXEL;
                end
                HEADER: if (out_ready) rd_address <= pix_cnt;
                LOAD:   out_data <= rd_data;
                PRESENT: if (out_ready && !last_pix) begin
                    pix_cnt    <= pix_cnt + 1'b1;
                    rd_address <= pix_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_pixel_streamer.sv
// Directed bench for frame_pixel_streamer on a 4-pixel frame with a
// synchronous RAM model returning 12'h100 + address.
module tb_frame_pixel_streamer;

    localparam int NP = 4;
    localparam int AW = 17;
    localparam int PW = 12;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          out_ready = 1'b1;
    logic [AW-1:0] rd_address;
    logic [PW-1:0] rd_data = '0;
    logic [PW-1:0] out_data;
    logic          frame_hold, out_valid, out_sop, out_eop, busy, done;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= 12'h100 + PW'(rd_address);

    frame_pixel_streamer #(
        .NUM_PIXELS  (NP),
        .ADDR_W      (AW),
        .PIX_W       (PW),
        .HEADER_PIXEL(12'h00A)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .rd_address (rd_address),
        .rd_data    (rd_data),
        .frame_hold (frame_hold),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sop    (out_sop),
        .out_eop    (out_eop),
        .busy       (busy),
        .done       (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs one frame from a start pulse; optional 5-cycle-style stall on
    // pixel 101 and optional start pokes mid-stream and during DONE.
    task automatic do_frame(input string nm, input int stall_len, input bit poke);
        logic [PW-1:0] got[$];
        logic [1:0]    flg[$];
        logic [AW-1:0] hold_addr;
        logic [PW-1:0] exp_px;
        logic [31:0]   obs;
        int exp_done, lim, done_cnt, done_cyc, stall_left;
        bit stalled, fh_ok, stall_ok;
        exp_done   = 14 + stall_len;
        lim        = exp_done + 3;
        done_cnt   = 0;
        done_cyc   = -1;
        stall_left = 0;
        stalled    = 1'b0;
        fh_ok      = 1'b1;
        stall_ok   = 1'b1;
        hold_addr  = '0;

        chk($sformatf("%s_fh_before", nm), frame_hold, 0);
        chk($sformatf("%s_busy_before", nm), busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= lim; c++) begin
            if (!stalled && stall_len > 0 && out_valid && !out_sop && out_data == 12'h101) begin
                stall_left = stall_len;
                stalled    = 1'b1;
                hold_addr  = rd_address;
            end
            out_ready = (stall_left == 0);
            if (stall_left > 0) begin
                if (!(out_valid && out_data == 12'h101 && rd_address == hold_addr)) stall_ok = 1'b0;
                stall_left--;
            end
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                flg.push_back({out_sop, out_eop});
            end
            if (done) begin
                done_cnt++;
                done_cyc = c;
            end
            if (frame_hold !== (c <= exp_done)) fh_ok = 1'b0;
            start = poke && (c == 5 || c == exp_done);
            tick();
        end
        start     = 1'b0;
        out_ready = 1'b1;

        chk($sformatf("%s_count", nm), got.size(), NP + 1);
        for (int i = 0; i <= NP; i++) begin
            exp_px = (i == 0) ? 12'h00A : PW'(12'h100 + i - 1);
            obs = (i < got.size()) ? {20'd0, got[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_pix%0d", nm, i), obs, {20'd0, exp_px});
            obs = (i < flg.size()) ? {30'd0, flg[i]} : 32'hFFFF_FFFF;
            chk($sformatf("%s_sopeop%0d", nm, i), obs, {30'd0, (i == 0), (i == NP)});
        end
        chk($sformatf("%s_done_cnt", nm), done_cnt, 1);
        chk($sformatf("%s_done_cyc", nm), done_cyc, exp_done);
        chk($sformatf("%s_fh_window", nm), fh_ok, 1);
        chk($sformatf("%s_busy_after", nm), busy, 0);
        if (stall_len > 0) begin
            chk($sformatf("%s_stalled", nm), stalled, 1);
            chk($sformatf("%s_stall_stable", nm), stall_ok, 1);
        end
    endtask

    initial begin
        bit found;
        tick();
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_fh", frame_hold, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_addr", rd_address, 0);
        chk("rst_done", done, 0);
        rst_n = 1'b1;
        tick();

        do_frame("basic", 0, 1'b0);
        do_frame("stall", 5, 1'b0);
        do_frame("poke", 0, 1'b1);

        // Reset while presenting pixel 102.
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            if (out_valid && out_data == 12'h102) found = 1'b1;
            else tick();
        end
        chk("mid_reach_102", found, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        chk("mid_rst_fh", frame_hold, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_addr", rd_address, 0);
        chk("mid_rst_eop", out_eop, 0);
        tick();
        chk("mid_rst_done0", done, 0);
        tick();
        chk("mid_rst_done1", done, 0);
        rst_n = 1'b1;
        tick();
        chk("mid_rst_done2", done, 0);
        do_frame("after_rst", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/frame_pixel_streamer.md
FRAME_PIXEL_STREAMER -- requirements
Module: frame_pixel_streamer

Interface
REQ-001 SHALL have parameter NUM_PIXELS, default 76800, meaning pixels per frame (320x240).
REQ-002 SHALL have parameter ADDR_W, default 17, meaning frame-buffer address width.
REQ-003 SHALL have parameter PIX_W, default 12, meaning pixel width (RGB444).
REQ-004 SHALL have parameter HEADER_PIXEL, default 12'h00A, meaning the frame-start marker pixel sent before image data.
REQ-005 Port: clk  in  1  single clock (50 MHz domain); one clock; reset is asynchronous and active-low.
REQ-006 Port: rst_n  in  1  asynchronous active-low reset.
REQ-007 Port: start  in  1  single-cycle request to stream one frame.
REQ-008 Port: rd_address  out  ADDR_W  frame-buffer read address.
REQ-009 Port: rd_data  in  PIX_W  frame-buffer read data, valid one cycle after rd_address.
REQ-010 Port: frame_hold  out  1  freezes camera writes into the frame buffer while high.
REQ-011 Port: out_valid  out  1  out_data holds a valid pixel.
REQ-012 Port: out_ready  in  1  downstream serializer accepts pixel when high with out_valid.
REQ-013 Port: out_data  out  PIX_W  pixel to serializer.
REQ-014 Port: out_sop  out  1  high with the header pixel.
REQ-015 Port: out_eop  out  1  high with the last image pixel.
REQ-016 Port: busy  out  1  high in any state except IDLE.
REQ-017 Port: done  out  1  single-cycle pulse after the last pixel is accepted.

Function
REQ-018 SHALL implement states IDLE, HEADER, FETCH, LOAD, PRESENT, DONE.
REQ-019 IDLE: start=1 -> HEADER, pixel counter cleared to 0; start in any other state SHALL be ignored.
REQ-020 HEADER: out_valid=1, out_data=HEADER_PIXEL, out_sop=1; on out_ready -> FETCH.
REQ-021 FETCH: rd_address registered to counter value; -> LOAD unconditionally.
REQ-022 LOAD: rd_data captured into out_data register; -> PRESENT.
REQ-023 PRESENT: out_valid=1; out_data SHALL stay stable until accepted; out_eop=1 when counter = NUM_PIXELS-1.
REQ-024 PRESENT with out_ready: counter = NUM_PIXELS-1 -> DONE, else counter+1 and -> FETCH.
REQ-025 DONE: done=1 for exactly one cycle; -> IDLE.
REQ-026 Throughput with out_ready held high: header 1 cycle, each image pixel 3 cycles (FETCH, LOAD, PRESENT).
REQ-027 frame_hold SHALL be high from the cycle after start is accepted through DONE inclusive, low in IDLE.
REQ-028 out_valid, out_sop, out_eop SHALL be 0 in IDLE, FETCH, LOAD, DONE.
REQ-029 Counter SHALL be ADDR_W bits, never exceed NUM_PIXELS-1, no wrap.
REQ-030 out_ready low SHALL stall HEADER/PRESENT indefinitely without data change.
REQ-031 start coincident with DONE SHALL be ignored (new frame needs start in IDLE).

Reset
REQ-032 rst_n low SHALL asynchronously force IDLE, counter=0, rd_address=0, out_data=0, all other outputs 0.
REQ-033 Reset mid-frame SHALL abort the frame; no done pulse; frame_hold drops immediately.

Structure
REQ-034 PIX_W, ADDR_W, NUM_PIXELS defaults, HEADER_PIXEL and the state enum SHALL live in shared package camera_pkg.
REQ-035 No sub-module; single FSM plus counter and data register.

Verification (NUM_PIXELS=4, RAM model returns 12'h100+address, 1-cycle latency)
REQ-036 start pulse, out_ready=1 -> accepted stream 00A(sop),100,101,102,103(eop); done 14 cycles after start; busy low after.
REQ-037 out_ready low 5 cycles during PRESENT of pixel 101 -> out_data stays 101, out_valid high, no extra rd_address change.
REQ-038 start pulsed during streaming and during DONE -> ignored, exactly one frame of 5 pixels emitted.
REQ-039 rst_n low while in PRESENT of pixel 102 -> outputs 0 same cycle, no done; subsequent start streams full frame from 00A.
REQ-040 frame_hold check: low before start, high every cycle from HEADER to DONE, low in next IDLE cycle.
